wb_grf: RTL
===========

Name: wb_grf

Overview:
- Writeback end of the MEM/WB pipeline register: consumes the register's outputs (IR, PC4, PC8, ALU result, memory read data, write address, Tnew).
- Selects the writeback value, commits it into the 32x32 general register file, and serves the two ID-stage read ports with internal write-through bypass.
- Emits a registered one-cycle writeback trace for the testbench/log and a sticky Tnew-violation flag.
- Sits between the MEM/WB register and the ID-stage operand path.

Parameters:
- WIDTH, 32, datapath width of registers, PCs and data.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ir_in  in  32  instruction in WB (from MEM/WB IR output)
- pc4_in  in  32  PC+4 of the WB instruction
- pc8_in  in  32  PC+8 of the WB instruction (link value)
- alu_result_in  in  32  ALU result carried from EX
- rd_in  in  32  memory read data carried from MEM
- write_addr_in  in  5  destination register; 0 means no write
- tnew_in  in  2  remaining Tnew of the WB instruction
- rs_addr  in  5  read port A address
- rt_addr  in  5  read port B address
- rs_data  out  32  read port A data (combinational)
- rt_data  out  32  read port B data (combinational)
- trace_valid  out  1  registered: a write committed last cycle
- trace_pc  out  32  registered: PC of the committed instruction (pc4_in-4)
- trace_addr  out  5  registered: destination register
- trace_data  out  32  registered: value written
- tnew_err  out  1  sticky: a write occurred with tnew_in != 0

Behaviour:
- Reset (reset low, asynchronous): all NREG registers = 0; trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0, tnew_err=0. Reset asserted mid-stream discards any in-flight write in that cycle.
- Source select, combinational from ir_in:
  - opcode 6'b100011 (lw) -> rd_in
  - opcode 6'b000011 (jal), or opcode 0 with funct 6'b001001 (jalr) -> pc8_in
  - all else -> alu_result_in
- Write enable: we = (write_addr_in != 0). Commit on the rising clk edge with reset high. Writes to address 0 are dropped; reg[0] always reads 0.
- Reads: rs_data = 0 if rs_addr==0; else the write data if we && rs_addr==write_addr_in (same-cycle bypass, so an ID read sees a WB result with zero latency); else reg[rs_addr]. rt_data is identical with rt_addr. Both ports may hit the same address; both get the bypass.
- Trace, one cycle latency: on each edge, trace_valid <= we; when we=1, trace_pc <= pc4_in-32'd4 (mod 2^32), trace_addr <= write_addr_in, trace_data <= selected value. When we=0, trace_pc/addr/data hold their previous values.
- tnew_err: set on an edge where we && tnew_in != 0. Cleared only by reset. The write still commits.
- Back-to-back writes to the same register: the last commit wins; each produces its own trace pulse.
- NOP bubbles (ir_in=0, write_addr_in=0): no write, trace_valid=0.

Decomposition:
- Shared package: opcode/funct constants (OP_LW, OP_JAL, OP_SPECIAL, FN_JALR), WIDTH/AW defaults, writeback-source enum {WB_ALU, WB_MEM, WB_PC8}.
- One natural sub-module: wb_src_sel (combinational IR decode plus 3:1 mux). The register array, bypass and trace stay in wb_grf.

Test Plan:
- Reset low mid-run after writing r5=0x1234 -> r5 reads 0 immediately; trace_valid=0; tnew_err=0.
- lw-format IR 0x8C050000, write_addr_in=5, rd_in=0xDEADBEEF, alu_result_in=0x10 -> same-cycle rs_addr=5 reads 0xDEADBEEF; next cycle trace_valid=1, trace_addr=5, trace_data=0xDEADBEEF.
- jal IR 0x0C000100, write_addr_in=31, pc4_in=0x3004, pc8_in=0x3008 -> r31=0x3008; trace_pc=0x3000.
- write_addr_in=0, alu_result_in=0xFFFFFFFF -> rs_addr=0 and rt_addr=0 read 0; trace_valid=0.
- Consecutive writes r7=1 then r7=2, with rt_addr=7 both cycles -> reads 1 then 2 (bypass); two trace pulses.
- Write r3 with tnew_in=2'b01 -> tnew_err=1 after the edge and stays 1 through later clean writes; r3 is still written.

Source files
------------

// File: rtl/wb_grf_pkg.sv
// Shared constants and writeback-source decode for the WB stage register file.
package wb_grf_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREG  = 32;
  localparam int DEF_AW    = 5;

  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC8 = 2'd2
  } wb_src_e;

  function automatic wb_src_e decode_src(input logic [5:0] opcode, input logic [5:0] funct);
    wb_src_e src;
    src = WB_ALU;
    if (opcode == OP_LW) begin
      src = WB_MEM;
    end else if (opcode == OP_JAL || (opcode == OP_SPECIAL && funct == FN_JALR)) begin
      src = WB_PC8;
    end
    return src;
  endfunction

endpackage

// File: rtl/wb_src_sel.sv
// Writeback value select: decodes the WB instruction and muxes ALU / memory / link value.
module wb_src_sel
  import wb_grf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] pc8_in,
  input  logic [WIDTH-1:0] alu_result_in,
  input  logic [WIDTH-1:0] rd_in,
  output logic [WIDTH-1:0] wb_data
);

  wb_src_e wb_src;

  always_comb begin
    wb_src = decode_src(opcode, funct);
    unique case (wb_src)
      WB_MEM:  wb_data = rd_in;
      WB_PC8:  wb_data = pc8_in;
      default: wb_data = alu_result_in;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage: commits the selected result into the register file, serves the
// two ID read ports with same-cycle bypass, and emits a one-cycle commit trace.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir_in,
  input  logic [WIDTH-1:0] pc4_in,
  input  logic [WIDTH-1:0] pc8_in,
  input  logic [WIDTH-1:0] alu_result_in,
  input  logic [WIDTH-1:0] rd_in,
  input  logic [AW-1:0]    write_addr_in,
  input  logic [1:0]       tnew_in,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  output logic             trace_valid,
  output logic [WIDTH-1:0] trace_pc,
  output logic [AW-1:0]    trace_addr,
  output logic [WIDTH-1:0] trace_data,
  output logic             tnew_err
);

  logic [WIDTH-1:0] wb_data;
  logic             we;
  logic             unused_ir_bits;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic             trace_valid_q, trace_valid_d;
  logic [WIDTH-1:0] trace_pc_q, trace_pc_d;
  logic [AW-1:0]    trace_addr_q, trace_addr_d;
  logic [WIDTH-1:0] trace_data_q, trace_data_d;
  logic             tnew_err_q, tnew_err_d;

  assign unused_ir_bits = ^ir_in[25:6];
  assign we = (write_addr_in != '0);

  wb_src_sel #(.WIDTH(WIDTH)) u_src_sel (
    .opcode        (ir_in[31:26]),
    .funct         (ir_in[5:0]),
    .pc8_in        (pc8_in),
    .alu_result_in (alu_result_in),
    .rd_in         (rd_in),
    .wb_data       (wb_data)
  );

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NREG; i++) begin
      if (we && write_addr_in == AW'(i)) regs_d[i] = wb_data;
    end
    regs_d[0] = '0;
  end

  // Bypass lets an ID-stage read see this cycle's WB result before it commits.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (we && rs_addr == write_addr_in) rs_data = wb_data;
    if (rs_addr == '0) rs_data = '0;
    rt_data = regs_q[rt_addr];
    if (we && rt_addr == write_addr_in) rt_data = wb_data;
    if (rt_addr == '0) rt_data = '0;
  end

  always_comb begin
    trace_valid_d = we;
    trace_pc_d    = trace_pc_q;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    if (we) begin
      trace_pc_d   = pc4_in - WIDTH'(4);
      trace_addr_d = write_addr_in;
      trace_data_d = wb_data;
    end
    tnew_err_d = tnew_err_q | (we && tnew_in != 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q        <= '{default: '0};
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
      tnew_err_q    <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
      tnew_err_q    <= tnew_err_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;
  assign tnew_err    = tnew_err_q;

endmodule
